// File: rtl/bias_add_0.sv
// bias_add_0: per-channel bias adder for conv layer 0.
// Each frame it first drains NUM_CH bias words from the bias fifo into a local
// bank. It then adds the matching bias to each channel-interleaved accumulator
// sample and writes the saturated result downstream through a one-entry
// output register.
// Ports:
//   ap_clk, ap_rst                   clock and async active-high reset
//   bias_V_dout/_empty_n/_read       bias ap_fifo input (COEFF_W, signed)
//   acc_V_dout/_empty_n/_read        accumulator ap_fifo input (ACC_W, signed)
//   output_V_din/_full_n/_write      biased-sample ap_fifo output (ACC_W, signed)
//   frame_done                       high in the cycle the frame's last sample transfers
module bias_add_0 #(
   parameter int unsigned NUM_CH    = 16,
   parameter int unsigned COEFF_W   = 16,
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned FRAME_PIX = 1024
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [COEFF_W-1:0] bias_V_dout,
   input  logic               bias_V_empty_n,
   output logic               bias_V_read,
   input  logic [ACC_W-1:0]   acc_V_dout,
   input  logic               acc_V_empty_n,
   output logic               acc_V_read,
   output logic [ACC_W-1:0]   output_V_din,
   input  logic               output_V_full_n,
   output logic               output_V_write,
   output logic               frame_done
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PIX_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam int unsigned EXT_W = ACC_W + 1 - COEFF_W;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_next;

   logic [CH_W-1:0]    ld_idx;
   logic [CH_W-1:0]    ch;
   logic [PIX_W-1:0]   pix;
   logic [COEFF_W-1:0] bias_reg [NUM_CH];

   logic [ACC_W-1:0]   out_reg;
   logic               out_valid;
   logic               out_last;

   logic               bias_take;
   logic               acc_take;
   logic               out_xfer;
   logic               ld_last;
   logic               ch_last;
   logic               pix_last;
   logic [COEFF_W-1:0] bias_sel;
   logic [ACC_W:0]     sum;
   logic [ACC_W-1:0]   sat_val;

   assign ld_last  = (ld_idx == CH_W'(NUM_CH - 1));
   assign ch_last  = (ch == CH_W'(NUM_CH - 1));
   assign pix_last = (pix == PIX_W'(FRAME_PIX - 1));

   assign bias_take = bias_V_read && bias_V_empty_n;
   assign acc_take  = acc_V_read && acc_V_empty_n;
   assign out_xfer  = out_valid && output_V_full_n;

   // State register
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= LOAD;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         LOAD: if (bias_take && ld_last) state_next = RUN;
         RUN:  if (acc_take && ch_last && pix_last) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   // FSM outputs: fifo pops; reads are held off while reset is asserted.
   // A new sample is accepted only when the output register is free or draining.
   always_comb begin
      bias_V_read = 1'b0;
      acc_V_read  = 1'b0;
      case (state)
         LOAD: bias_V_read = bias_V_empty_n && !ap_rst;
         RUN:  acc_V_read  = acc_V_empty_n && (!out_valid || output_V_full_n) && !ap_rst;
         default: ;
      endcase
   end

   // Load index, channel and pixel counters; each wraps so the next phase starts at 0
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         ld_idx <= '0;
         ch     <= '0;
         pix    <= '0;
      end else begin
         if (bias_take) ld_idx <= ld_last ? '0 : ld_idx + CH_W'(1);
         if (acc_take) begin
            ch <= ch_last ? '0 : ch + CH_W'(1);
            if (ch_last) pix <= pix_last ? '0 : pix + PIX_W'(1);
         end
      end
   end

   // Bias bank: contents are reloaded every frame, so no reset is needed
   always_ff @(posedge ap_clk) begin
      if (bias_take) bias_reg[ld_idx] <= bias_V_dout;
   end

   // Sign-extended add in ACC_W+1 bits, then clamp to the signed ACC_W range
   always_comb begin
      bias_sel = bias_reg[ch];
      sum      = {acc_V_dout[ACC_W-1], acc_V_dout} + {{EXT_W{bias_sel[COEFF_W-1]}}, bias_sel};
      sat_val  = sum[ACC_W-1:0];
      if (sum[ACC_W] != sum[ACC_W-1])
         sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   // Output register: drains independently of the FSM state; a new load wins over a drain
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         out_reg   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (acc_take) begin
         out_reg   <= sat_val;
         out_valid <= 1'b1;
         out_last  <= ch_last && pix_last;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   assign output_V_din   = out_reg;
   assign output_V_write = out_valid;
   // Aligned with the downstream transfer of the frame-last sample
   assign frame_done     = out_valid && out_last && output_V_full_n;

endmodule

// File: tb/tb_bias_add_0.sv
// tb_bias_add_0: scoreboard bench for bias_add_0 (NUM_CH=4, FRAME_PIX=2).
// Bench fifo models feed the bias/acc streams and expected results are queued
// at stimulus time. A monitor pops and compares on every downstream transfer.
module tb_bias_add_0;

   localparam int unsigned NCH  = 4;
   localparam int unsigned NPIX = 2;
   localparam int unsigned NS   = NCH * NPIX;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic [15:0] bias_V_dout;
   logic        bias_V_empty_n;
   logic        bias_V_read;
   logic [31:0] acc_V_dout;
   logic        acc_V_empty_n;
   logic        acc_V_read;
   logic [31:0] output_V_din;
   logic        output_V_full_n;
   logic        output_V_write;
   logic        frame_done;

   typedef struct {
      logic [31:0] d;
      logic        last;
   } exp_t;

   logic [15:0] bq [$];
   logic [31:0] aq [$];
   exp_t        eq [$];

   int n_checks = 0;
   int n_pass   = 0;
   int xfer_cnt = 0;
   int cyc      = 0;
   int first_cyc = 0;
   int last_cyc  = 0;
   bit rand_full = 1'b0;

   bias_add_0 #(
      .NUM_CH(NCH), .COEFF_W(16), .ACC_W(32), .FRAME_PIX(NPIX)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst(ap_rst),
      .bias_V_dout(bias_V_dout),
      .bias_V_empty_n(bias_V_empty_n),
      .bias_V_read(bias_V_read),
      .acc_V_dout(acc_V_dout),
      .acc_V_empty_n(acc_V_empty_n),
      .acc_V_read(acc_V_read),
      .output_V_din(output_V_din),
      .output_V_full_n(output_V_full_n),
      .output_V_write(output_V_write),
      .frame_done(frame_done)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Fifo models: handshakes captured mid-cycle, pops and new drive values applied just after the edge
   initial begin
      bias_V_dout = '0; bias_V_empty_n = 1'b0;
      acc_V_dout = '0;  acc_V_empty_n = 1'b0;
      output_V_full_n = 1'b1;
      forever begin
         bit bt, at;
         @(negedge ap_clk);
         bt = bias_V_read && bias_V_empty_n;
         at = acc_V_read && acc_V_empty_n;
         @(posedge ap_clk);
         #1;
         if (bt && bq.size() > 0) void'(bq.pop_front());
         if (at && aq.size() > 0) void'(aq.pop_front());
         bias_V_empty_n  = (bq.size() > 0);
         bias_V_dout     = (bq.size() > 0) ? bq[0] : 16'h0;
         acc_V_empty_n   = (aq.size() > 0);
         acc_V_dout      = (aq.size() > 0) ? aq[0] : 32'h0;
         output_V_full_n = rand_full ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares every downstream transfer against the scoreboard
   initial begin
      bit          hold;
      logic [31:0] held;
      exp_t        e;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge ap_clk);
         cyc++;
         if (ap_rst) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("hold_write", 64'(output_V_write), 64'd1);
               check("hold_din", 64'(output_V_din), 64'(held));
            end
            hold = output_V_write && !output_V_full_n;
            held = output_V_din;
            if (output_V_write && output_V_full_n) begin
               if (eq.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_write: got din 0x%0h, expected no write", output_V_din);
               end else begin
                  e = eq.pop_front();
                  check("dout", 64'(output_V_din), 64'(e.d));
                  check("frame_done", 64'(frame_done), 64'(e.last));
                  if (xfer_cnt == 0) first_cyc = cyc;
                  last_cyc = cyc;
                  xfer_cnt++;
               end
            end else if (frame_done) begin
               check("spurious_frame_done", 64'(frame_done), 64'd0);
            end
         end
      end
   end

   task automatic push_biases(input logic [15:0] b [NCH]);
      for (int i = 0; i < int'(NCH); i++) bq.push_back(b[i]);
   endtask

   task automatic push_accs(input logic [31:0] a [NS], input logic [31:0] x [NS]);
      exp_t e;
      for (int i = 0; i < int'(NS); i++) begin
         aq.push_back(a[i]);
         e.d = x[i];
         e.last = (i == int'(NS) - 1);
         eq.push_back(e);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && eq.size() > 0; i++) @(negedge ap_clk);
      check(name, 64'(eq.size()), 64'd0);
      repeat (2) @(negedge ap_clk);
   endtask

   initial begin
      logic [15:0] b [NCH];
      logic [31:0] a [NS];
      logic [31:0] x [NS];

      repeat (3) @(posedge ap_clk);
      #1 ap_rst = 1'b0;

      // Reset/idle: empty fifos, nothing read or written
      repeat (20) begin
         @(negedge ap_clk);
         check("idle", 64'({bias_V_read, acc_V_read, output_V_write, frame_done, output_V_din}), 64'd0);
      end

      // Basic frame, unstalled
      xfer_cnt = 0;
      b = '{16'd1, 16'hFFFE, 16'd3, 16'hFFFC};
      a = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
      x = '{32'd11, 32'd9, 32'd15, 32'd9, 32'd15, 32'd13, 32'd19, 32'd13};
      push_biases(b);
      push_accs(a, x);
      wait_drain("basic_drain");
      check("basic_count", 64'(xfer_cnt), 64'd8);
      check("basic_throughput", 64'(last_cyc - first_cyc), 64'd7);

      // Saturation at both rails plus near-rail non-saturating sums
      xfer_cnt = 0;
      b = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
      a = '{32'h7FFFFFF0, 32'h80000005, 32'h7FFFFFFF, 32'h80000000,
            32'h00000010, 32'hFFFF8000, 32'h7FFFFFFE, 32'h00000000};
      x = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
            32'h0000800F, 32'hFFFF0000, 32'h7FFFFFFF, 32'hFFFFFFFF};
      push_biases(b);
      push_accs(a, x);
      wait_drain("sat_drain");
      check("sat_count", 64'(xfer_cnt), 64'd8);

      // Backpressure: random output stalls, same sequence expected
      xfer_cnt = 0;
      rand_full = 1'b1;
      b = '{16'd1, 16'hFFFE, 16'd3, 16'hFFFC};
      a = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
      x = '{32'd11, 32'd9, 32'd15, 32'd9, 32'd15, 32'd13, 32'd19, 32'd13};
      push_biases(b);
      push_accs(a, x);
      wait_drain("bp_drain");
      rand_full = 1'b0;
      check("bp_count", 64'(xfer_cnt), 64'd8);

      // Back-to-back frames with the second bias set withheld
      xfer_cnt = 0;
      b = '{16'd100, 16'd200, 16'd300, 16'd400};
      a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
      x = '{32'd100, 32'd201, 32'd302, 32'd403, 32'd104, 32'd205, 32'd306, 32'd407};
      push_biases(b);
      push_accs(a, x);
      a = '{32'd1000, 32'd1001, 32'd1002, 32'd1003, 32'd1004, 32'd1005, 32'd1006, 32'd1007};
      x = '{32'd900, 32'd801, 32'd702, 32'd603, 32'd904, 32'd805, 32'd706, 32'd607};
      push_accs(a, x);
      for (int i = 0; i < 200 && eq.size() > int'(NS); i++) @(negedge ap_clk);
      check("b2b_first_drain", 64'(eq.size()), 64'(NS));
      repeat (10) @(negedge ap_clk);
      check("starve_acc_untouched", 64'(aq.size()), 64'(NS));
      check("starve_no_write", 64'(eq.size()), 64'(NS));
      check("starve_acc_read", 64'(acc_V_read), 64'd0);
      b = '{16'hFF9C, 16'hFF38, 16'hFED4, 16'hFE70};
      push_biases(b);
      wait_drain("b2b_drain");
      check("b2b_count", 64'(xfer_cnt), 64'd16);

      // Mid-frame reset after 5 outputs, then a fresh frame
      xfer_cnt = 0;
      b = '{16'd1, 16'hFFFE, 16'd3, 16'hFFFC};
      a = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
      x = '{32'd11, 32'd9, 32'd15, 32'd9, 32'd15, 32'd13, 32'd19, 32'd13};
      push_biases(b);
      push_accs(a, x);
      for (int i = 0; i < 200 && xfer_cnt < 5; i++) @(negedge ap_clk);
      check("pre_reset_outputs", 64'(xfer_cnt >= 5), 64'd1);
      @(posedge ap_clk);
      #3 ap_rst = 1'b1;
      #1;
      check("rst_clear", 64'({output_V_write, frame_done, acc_V_read, bias_V_read, output_V_din}), 64'd0);
      bq.delete();
      aq.delete();
      eq.delete();
      repeat (2) @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      xfer_cnt = 0;
      b = '{16'd5, 16'd6, 16'd7, 16'd8};
      a = '{32'hFFFFFFF6, 32'hFFFFFFF7, 32'hFFFFFFF8, 32'hFFFFFFF9,
            32'hFFFFFFFA, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'hFFFFFFFD};
      x = '{32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000001,
            32'hFFFFFFFF, 32'h00000001, 32'h00000003, 32'h00000005};
      push_biases(b);
      push_accs(a, x);
      wait_drain("post_reset_drain");
      check("post_reset_count", 64'(xfer_cnt), 64'd8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
